// File: rtl/keypad_pkg.sv
// Shared keypad constants: FSM encoding, column/row patterns and the key codes
// that vending_machine decodes.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kp_state_e;

    localparam logic [3:0] COL_IDLE = 4'b1111;
    localparam logic [3:0] COL0     = 4'b1110;
    localparam logic [3:0] COL1     = 4'b1101;
    localparam logic [3:0] COL2     = 4'b1011;
    localparam logic [3:0] COL3     = 4'b0111;
    localparam logic [3:0] ROW_NONE = 4'b1111;

    localparam logic [3:0] KEY_0 = 4'd0;
    localparam logic [3:0] KEY_1 = 4'd1;
    localparam logic [3:0] KEY_2 = 4'd2;
    localparam logic [3:0] KEY_3 = 4'd3;
    localparam logic [3:0] KEY_4 = 4'd4;
    localparam logic [3:0] KEY_5 = 4'd5;
    localparam logic [3:0] KEY_6 = 4'd6;
    localparam logic [3:0] KEY_7 = 4'd7;
    localparam logic [3:0] KEY_8 = 4'd8;
    localparam logic [3:0] KEY_9 = 4'd9;
    localparam logic [3:0] KEY_A = 4'd10;
    localparam logic [3:0] KEY_B = 4'd11;
    localparam logic [3:0] KEY_C = 4'd12;
    localparam logic [3:0] KEY_D = 4'd13;
    localparam logic [3:0] KEY_E = 4'd14;
    localparam logic [3:0] KEY_F = 4'd15;

    // True when exactly one row line is pulled low; ghosted multi-key samples fail this.
    function automatic logic row_single_low(input logic [3:0] r);
        logic [3:0] act;
        act = ~r;
        return (act != 4'd0) && ((act & (act - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] row_index(input logic [3:0] r);
        logic [1:0] idx;
        case (r)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        logic [3:0] c;
        case (idx)
            2'd0:    c = COL0;
            2'd1:    c = COL1;
            2'd2:    c = COL2;
            default: c = COL3;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/keypad_stable_counter.sv
// Counts consecutive matching clocks; done_c fires on the CYCLES-th match and the count restarts.
module keypad_stable_counter #(
    parameter int unsigned CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic match,
    output logic done_c
);

    localparam int unsigned CNT_W = $clog2(CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign done_c = enable && match && (cnt_q == CNT_W'(CYCLES - 1));

    // Restart on done so the next state begins its own count from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || (enable && !match) || done_c) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CNT_W'(CYCLES))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: rotates active-low column drive, debounces press and release,
// and emits one key_valid pulse with key_code = col*4 + row per accepted press.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] shift_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned DWELL_W = $clog2(SCAN_DIV);

    kp_state_e        state_q, state_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [3:0]       row_pat_q, row_pat_d;
    logic [3:0]       shift_col_q, shift_col_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;

    logic             stab_clear_c;
    logic             stab_en_c;
    logic             stab_match_c;
    logic             stab_done_c;
    logic [1:0]       next_col_c;

    assign next_col_c   = col_idx_q + 2'd1;
    assign stab_clear_c = (state_q == SCAN);
    assign stab_en_c    = (state_q != SCAN);
    assign stab_match_c = (state_q == DEBOUNCE) ? (row == row_pat_q) : (row == ROW_NONE);

    keypad_stable_counter #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_stab (
        .clk    (clk),
        .reset  (reset),
        .clear  (stab_clear_c),
        .enable (stab_en_c),
        .match  (stab_match_c),
        .done_c (stab_done_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        dwell_d     = dwell_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        row_pat_d   = row_pat_q;
        shift_col_d = shift_col_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_W'(SCAN_DIV - 1)) begin
                    dwell_d = '0;
                    if (row_single_low(row)) begin
                        row_pat_d = row;
                        row_idx_d = row_index(row);
                        state_d   = DEBOUNCE;
                    end else begin
                        col_idx_d   = next_col_c;
                        shift_col_d = col_drive(next_col_c);
                    end
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end
            DEBOUNCE: begin
                if (!stab_match_c) begin
                    state_d     = SCAN;
                    dwell_d     = '0;
                    col_idx_d   = next_col_c;
                    shift_col_d = col_drive(next_col_c);
                end else if (stab_done_c) begin
                    key_code_d  = {col_idx_q, row_idx_q};
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                    state_d     = HELD;
                end
            end
            HELD: begin
                if (stab_done_c) begin
                    key_held_d  = 1'b0;
                    state_d     = SCAN;
                    dwell_d     = '0;
                    col_idx_d   = next_col_c;
                    shift_col_d = col_drive(next_col_c);
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SCAN;
            dwell_q     <= '0;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            row_pat_q   <= ROW_NONE;
            shift_col_q <= COL0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            row_pat_q   <= row_pat_d;
            shift_col_q <= shift_col_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign shift_col = shift_col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: physical keypad model, cycle model of the scanner rules,
// per-cycle output compare, key-code scoreboard and directed literal checks.
module tb_keypad_scan_ctrl;

    localparam int SD  = 4;
    localparam int DEB = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row;
    logic [3:0] shift_col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .shift_col (shift_col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int valid_cnt = 0;
    int pushed = 0;
    logic cmp_en = 1'b0;
    int exp_q[$];

    // Physical keypad: a pressed key pulls its row low only while its column is driven.
    logic       key_down = 1'b0;
    logic [1:0] kc = 2'd0;
    logic [1:0] kr = 2'd0;
    logic       force_en = 1'b0;
    logic [3:0] force_val = 4'hF;
    logic [3:0] kc_drive;

    always_comb begin
        kc_drive = 4'(~(4'b0001 << kc));
        row = 4'hF;
        if (force_en) row = force_val;
        else if (key_down && (shift_col == kc_drive)) row = 4'(~(4'b0001 << kr));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 scanning, 1 confirming a press, 2 waiting for release.
    int m_mode = 0, m_col = 0, m_tick = 0, m_run = 0, m_rowi = 0;
    logic [3:0] m_pat = 4'hF, m_code = 4'd0;
    logic m_valid = 1'b0, m_held = 1'b0;

    always @(posedge clk) begin
        int lows;
        if (reset) begin
            m_mode = 0; m_col = 0; m_tick = 0; m_run = 0; m_pat = 4'hF;
            m_code = 4'd0; m_valid = 1'b0; m_held = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (m_mode == 0) begin
                if (m_tick == SD - 1) begin
                    m_tick = 0;
                    lows = 0;
                    for (int i = 0; i < 4; i++) if (!row[i]) begin lows++; m_rowi = i; end
                    if (lows == 1) begin m_pat = row; m_mode = 1; m_run = 0; end
                    else m_col = (m_col + 1) % 4;
                end else m_tick++;
            end else if (m_mode == 1) begin
                if (row == m_pat) begin
                    m_run++;
                    if (m_run == DEB) begin
                        m_code = 4'(m_col * 4 + m_rowi); m_valid = 1'b1; m_held = 1'b1;
                        m_mode = 2; m_run = 0;
                    end
                end else begin m_mode = 0; m_col = (m_col + 1) % 4; m_tick = 0; end
            end else begin
                if (row == 4'hF) begin
                    m_run++;
                    if (m_run == DEB) begin m_held = 1'b0; m_mode = 0; m_col = (m_col + 1) % 4; m_tick = 0; end
                end else m_run = 0;
            end
        end
    end

    // Per-cycle compare against the model plus key-code scoreboard.
    always @(negedge clk) begin
        logic [3:0] exp_col;
        int e;
        if (cmp_en) begin
            exp_col = 4'(~(4'b0001 << m_col));
            check("cycle", {shift_col, key_code, key_valid, key_held},
                  {exp_col, m_code, m_valid, m_held});
            if (key_valid === 1'b1) begin
                valid_cnt++;
                if (exp_q.size() == 0) check("sb_unexpected_valid", {28'd0, key_code}, 32'hFFFF_FFFF);
                else begin e = exp_q.pop_front(); check("sb_code", {28'd0, key_code}, e); end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (key_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        if (key_valid !== 1'b1) check({name, "_valid_timeout"}, 0, 1);
    endtask

    task automatic wait_mode(input int mode, input string name);
        int n = 0;
        while (m_mode != mode && n < 300) begin @(negedge clk); n++; end
        if (m_mode != mode) check({name, "_mode_timeout"}, m_mode, mode);
    endtask

    task automatic press_release(input int c, input int r);
        int n = 0;
        kc = 2'(c); kr = 2'(r); key_down = 1'b1;
        exp_q.push_back(c * 4 + r); pushed++;
        wait_valid("sweep");
        tick(3);
        key_down = 1'b0;
        while (key_held !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        if (key_held !== 1'b0) check("sweep_release_timeout", 1, 0);
        tick(2);
    endtask

    initial begin
        int v0, changes;
        logic [3:0] prev;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, changes;
        logic [3:0] prev;
        // 1. reset and column rotation
        reset = 1'b1;
        tick(5);
        cmp_en = 1'b1;
        check("reset_outputs", {shift_col, key_valid, key_held}, {4'b1110, 1'b0, 1'b0});
        reset = 1'b0;
        tick(3);
        check("col0_dwell", shift_col, 4'b1110);
        tick(1);
        check("col1_after_4", shift_col, 4'b1101);
        tick(4);
        check("col2_after_8", shift_col, 4'b1011);

        // 2. key col1/row2 -> code 6, single pulse, release timing
        kc = 2'd1; kr = 2'd2; key_down = 1'b1;
        exp_q.push_back(6); pushed++;
        v0 = valid_cnt;
        wait_valid("key6");
        check("key6_code", key_code, 4'd6);
        check("key6_held", key_held, 1'b1);
        tick(12);
        check("key6_single_pulse", valid_cnt - v0, 1);
        key_down = 1'b0;
        tick(7);
        check("key6_held_7_release", key_held, 1'b1);
        tick(1);
        check("key6_released_8", key_held, 1'b0);
        tick(3);

        // 3. aborted debounce on col3/row3 -> no pulse, scan wraps to column 0
        v0 = valid_cnt;
        kc = 2'd3; kr = 2'd3; key_down = 1'b1;
        wait_mode(1, "abort");
        tick(3);
        force_en = 1'b1; force_val = 4'hF;
        tick(1);
        force_en = 1'b0; key_down = 1'b0;
        check("abort_wrap_col0", shift_col, 4'b1110);
        tick(20);
        check("abort_no_valid", valid_cnt - v0, 0);

        // 4. ghosting: two rows low for 40 clk
        v0 = valid_cnt;
        changes = 0;
        force_en = 1'b1; force_val = 4'b1001;
        prev = shift_col;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (shift_col != prev) changes++;
            prev = shift_col;
        end
        force_en = 1'b0;
        check("ghost_no_valid", valid_cnt - v0, 0);
        check("ghost_rotations", changes, 10);
        tick(3);

        // 5. release glitch in HELD
        kc = 2'd0; kr = 2'd0; key_down = 1'b1;
        exp_q.push_back(0); pushed++;
        v0 = valid_cnt;
        wait_valid("glitch");
        tick(3);
        key_down = 1'b0;
        tick(4);
        force_en = 1'b1; force_val = 4'b0111;
        tick(1);
        force_en = 1'b0;
        tick(7);
        check("glitch_held_still", key_held, 1'b1);
        tick(1);
        check("glitch_released", key_held, 1'b0);
        check("glitch_single_pulse", valid_cnt - v0, 1);
        tick(3);

        // 6. reset during DEBOUNCE and during HELD
        kc = 2'd2; kr = 2'd1; key_down = 1'b1;
        wait_mode(1, "rst_deb");
        tick(2);
        reset = 1'b1;
        tick(1);
        check("rst_deb_outputs", {shift_col, key_code, key_valid, key_held}, {4'b1110, 4'd0, 1'b0, 1'b0});
        reset = 1'b0; key_down = 1'b0;
        tick(3);
        kc = 2'd1; kr = 2'd3; key_down = 1'b1;
        exp_q.push_back(7); pushed++;
        wait_valid("rst_held");
        check("rst_held_code", key_code, 4'd7);
        tick(2);
        reset = 1'b1;
        tick(1);
        check("rst_held_outputs", {shift_col, key_code, key_valid, key_held}, {4'b1110, 4'd0, 1'b0, 1'b0});
        reset = 1'b0; key_down = 1'b0;
        tick(3);

        // Sweep all 16 keys in order.
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                press_release(c, r);

        tick(5);
        check("sb_drained", exp_q.size(), 0);
        check("total_valids", valid_cnt, pushed);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
